// File: rtl/gpio_config_shift_ctrl_if.sv
// gpio_config_shift_ctrl_if
//   Bundles the pad-config controller's management-side signals.
//   master: management chain / defaults block (drives strobes, data, defaults)
//   slave : gpio_config_shift_ctrl (drives serial_data_out, cfg_out, status)
// Signals:
//   gpio_defaults   static defaults word from gpio_defaults_block_NNN
//   defaults_reload 1-cycle strobe, restore defaults
//   serial_shift    1-cycle strobe, shift in serial_data_in
//   serial_data_in  serial bit
//   serial_load     1-cycle strobe, commit the shifted frame
//   serial_data_out shift register MSB, to next pad in the chain
//   cfg_out         live pad configuration
//   cfg_valid       1-cycle pulse when cfg_out is committed
//   busy            high during the commit cycle
//   load_err        sticky rejected-load flag
interface gpio_config_shift_ctrl_if #(
  parameter int CFG_WIDTH = 10
);
  logic [CFG_WIDTH-1:0] gpio_defaults;
  logic                 defaults_reload;
  logic                 serial_shift;
  logic                 serial_data_in;
  logic                 serial_load;
  logic                 serial_data_out;
  logic [CFG_WIDTH-1:0] cfg_out;
  logic                 cfg_valid;
  logic                 busy;
  logic                 load_err;

  modport master (
    output gpio_defaults, defaults_reload, serial_shift, serial_data_in, serial_load,
    input  serial_data_out, cfg_out, cfg_valid, busy, load_err
  );

  modport slave (
    input  gpio_defaults, defaults_reload, serial_shift, serial_data_in, serial_load,
    output serial_data_out, cfg_out, cfg_valid, busy, load_err
  );
endinterface

// File: rtl/gpio_config_shift_ctrl.sv
// gpio_config_shift_ctrl
//   Per-pad configuration register. Captures the gpio_defaults word at reset,
//   accepts a serial MSB-first reconfiguration frame, commits it to cfg_out on
//   a load strobe and forwards the shift register MSB for daisy-chaining.
// Ports:
//   wb_clk_i  system clock, all state on the rising edge
//   wb_rst_i  synchronous reset, active-high
//   cfg       gpio_config_shift_ctrl_if.slave (strobes, serial data, cfg_out, status)
// Configuration macro:
//   GPIO_CFG_PARITY_EN  frame carries a trailing even-parity bit; loads with bad
//                       parity are rejected. Undefined: data-only frame.
//
// state  | meaning
// IDLE   | no frame bits since last load/reload/reset
// SHIFT  | at least one frame bit received
// COMMIT | one cycle after an accepted load/reload; cfg_valid=busy=1, strobes ignored
module gpio_config_shift_ctrl #(
  parameter int CFG_WIDTH = 10
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  gpio_config_shift_ctrl_if.slave cfg
);
`ifdef GPIO_CFG_PARITY_EN
  localparam int FRAME_W = CFG_WIDTH + 1;
`else
  localparam int FRAME_W = CFG_WIDTH;
`endif
  localparam int CNT_W = $clog2(FRAME_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t               state;
  logic [FRAME_W-1:0]   shift_reg;
  logic [CNT_W-1:0]     bit_cnt;
  logic [CFG_WIDTH-1:0] cfg_reg;
  logic                 cfg_valid_r;
  logic                 busy_r;
  logic                 load_err_r;

  logic [FRAME_W-1:0]   defaults_frame;
  logic [CFG_WIDTH-1:0] frame_data;
  logic                 parity_ok;
  logic                 frame_full;

`ifdef GPIO_CFG_PARITY_EN
  // Defaults sit in the data field with a zero parity slot below them.
  assign defaults_frame = {cfg.gpio_defaults, 1'b0};
  assign frame_data     = shift_reg[CFG_WIDTH:1];
  assign parity_ok      = ~^shift_reg;
`else
  assign defaults_frame = cfg.gpio_defaults;
  assign frame_data     = shift_reg;
  assign parity_ok      = 1'b1;
`endif

  assign frame_full = (bit_cnt == CNT_W'(FRAME_W));

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state       <= IDLE;
      shift_reg   <= defaults_frame;
      cfg_reg     <= cfg.gpio_defaults;
      bit_cnt     <= '0;
      cfg_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      load_err_r  <= 1'b0;
    end else begin
      cfg_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      case (state)
        COMMIT: state <= IDLE;
        default: begin
          if (cfg.defaults_reload) begin
            shift_reg   <= defaults_frame;
            cfg_reg     <= cfg.gpio_defaults;
            bit_cnt     <= '0;
            state       <= COMMIT;
            cfg_valid_r <= 1'b1;
            busy_r      <= 1'b1;
          end else if (cfg.serial_load) begin
            bit_cnt <= '0;
            if (frame_full && parity_ok) begin
              cfg_reg     <= frame_data;
              state       <= COMMIT;
              cfg_valid_r <= 1'b1;
              busy_r      <= 1'b1;
            end else begin
              load_err_r <= 1'b1;
              state      <= IDLE;
            end
          end else if (cfg.serial_shift) begin
            // Shifting continues past a full count so chained frames pass through.
            shift_reg <= {shift_reg[FRAME_W-2:0], cfg.serial_data_in};
            if (!frame_full) bit_cnt <= bit_cnt + CNT_W'(1);
            state <= SHIFT;
          end
        end
      endcase
    end
  end

  assign cfg.serial_data_out = shift_reg[FRAME_W-1];
  assign cfg.cfg_out         = cfg_reg;
  assign cfg.cfg_valid       = cfg_valid_r;
  assign cfg.busy            = busy_r;
  assign cfg.load_err        = load_err_r;
endmodule

// File: tb/tb_gpio_config_shift_ctrl.sv
// tb_gpio_config_shift_ctrl
//   Self-checking bench for gpio_config_shift_ctrl: directed scenarios plus a
//   randomized run against a frame-level reference model.
module tb_gpio_config_shift_ctrl;
  localparam int CW = 10;
`ifdef GPIO_CFG_PARITY_EN
  localparam int FW = CW + 1;
`else
  localparam int FW = CW;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  gpio_config_shift_ctrl_if #(.CFG_WIDTH(CW)) ifc ();

  gpio_config_shift_ctrl #(.CFG_WIDTH(CW)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .cfg      (ifc)
  );

  // Reference model: the frame as a plain value, a received-bit count, the
  // committed configuration, the sticky error and whether a commit is showing.
  logic [FW-1:0] m_sr;
  int            m_cnt;
  logic [CW-1:0] m_cfg;
  bit            m_err;
  bit            m_commit;

  function automatic logic [FW-1:0] frame_of(input logic [CW-1:0] d, input bit bad_par);
`ifdef GPIO_CFG_PARITY_EN
    return {d, (^d) ^ bad_par};
`else
    return d;
`endif
  endfunction

  function automatic logic [FW-1:0] dflt_frame(input logic [CW-1:0] d);
`ifdef GPIO_CFG_PARITY_EN
    return {d, 1'b0};
`else
    return d;
`endif
  endfunction

  function automatic logic [CW-1:0] data_of(input logic [FW-1:0] f);
`ifdef GPIO_CFG_PARITY_EN
    return f[FW-1:1];
`else
    return f;
`endif
  endfunction

  function automatic bit frame_good(input logic [FW-1:0] f);
`ifdef GPIO_CFG_PARITY_EN
    return (^f) == 1'b0;
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_update(input bit r, input bit reload, input bit load,
                              input bit shift, input bit din);
    logic [FW:0] wide;
    if (r) begin
      m_sr = dflt_frame(ifc.gpio_defaults);
      m_cfg = ifc.gpio_defaults;
      m_cnt = 0;
      m_err = 0;
      m_commit = 0;
    end else if (m_commit) begin
      m_commit = 0;
    end else if (reload) begin
      m_sr = dflt_frame(ifc.gpio_defaults);
      m_cfg = ifc.gpio_defaults;
      m_cnt = 0;
      m_commit = 1;
    end else if (load) begin
      if (m_cnt == FW && frame_good(m_sr)) begin
        m_cfg = data_of(m_sr);
        m_commit = 1;
      end else begin
        m_err = 1;
      end
      m_cnt = 0;
    end else if (shift) begin
      wide = {m_sr, din};
      m_sr = wide[FW-1:0];
      m_cnt = (m_cnt + 1 > FW) ? FW : m_cnt + 1;
    end
  endtask

  // One clock of stimulus; inputs change 1 time unit after the edge.
  task automatic cycle(input bit r, input bit reload, input bit load,
                       input bit shift, input bit din);
    rst = r;
    ifc.defaults_reload = reload;
    ifc.serial_load = load;
    ifc.serial_shift = shift;
    ifc.serial_data_in = din;
    @(posedge clk);
    #1;
    model_update(r, reload, load, shift, din);
    rst = 1'b0;
    ifc.defaults_reload = 1'b0;
    ifc.serial_load = 1'b0;
    ifc.serial_shift = 1'b0;
    ifc.serial_data_in = 1'b0;
  endtask

  task automatic shift_frame(input logic [FW-1:0] f);
    for (int i = FW - 1; i >= 0; i--) cycle(0, 0, 0, 1, f[i]);
  endtask

  task automatic test_reset;
    ifc.gpio_defaults = 10'h009;
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    checks++; if (ifc.cfg_out !== 10'h009) begin errors++; $display("FAIL reset_cfg_out: got %h want %h", ifc.cfg_out, 10'h009); end
    checks++; if (ifc.serial_data_out !== 1'b0) begin errors++; $display("FAIL reset_sdo: got %b want 0", ifc.serial_data_out); end
    checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", ifc.busy); end
    checks++; if (ifc.load_err !== 1'b0) begin errors++; $display("FAIL reset_load_err: got %b want 0", ifc.load_err); end
    checks++; if (ifc.cfg_valid !== 1'b0) begin errors++; $display("FAIL reset_cfg_valid: got %b want 0", ifc.cfg_valid); end
  endtask

  task automatic test_load_frame;
    logic [FW-1:0] f;
    f = frame_of(10'h3A5, 0);
    for (int i = FW - 1; i >= 0; i--) begin
      cycle(0, 0, 0, 1, f[i]);
      checks++; if (ifc.serial_data_out !== m_sr[FW-1]) begin errors++; $display("FAIL load_sdo[%0d]: got %b want %b", i, ifc.serial_data_out, m_sr[FW-1]); end
    end
    cycle(0, 0, 1, 0, 0);
    checks++; if (ifc.cfg_out !== 10'h3A5) begin errors++; $display("FAIL load_cfg_out: got %h want %h", ifc.cfg_out, 10'h3A5); end
    checks++; if (ifc.cfg_valid !== 1'b1) begin errors++; $display("FAIL load_cfg_valid: got %b want 1", ifc.cfg_valid); end
    checks++; if (ifc.busy !== 1'b1) begin errors++; $display("FAIL load_busy: got %b want 1", ifc.busy); end
    cycle(0, 0, 0, 0, 0);
    checks++; if (ifc.cfg_valid !== 1'b0) begin errors++; $display("FAIL load_valid_pulse: got %b want 0", ifc.cfg_valid); end
    checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL load_busy_drop: got %b want 0", ifc.busy); end
    checks++; if (ifc.cfg_out !== 10'h3A5) begin errors++; $display("FAIL load_cfg_hold: got %h want %h", ifc.cfg_out, 10'h3A5); end
  endtask

  task automatic test_short_frame;
    logic [CW-1:0] d;
    ifc.gpio_defaults = 10'h009;
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) cycle(0, 0, 0, 1, 1'($urandom_range(0, 1)));
    cycle(0, 0, 1, 0, 0);
    checks++; if (ifc.load_err !== 1'b1) begin errors++; $display("FAIL short_load_err: got %b want 1", ifc.load_err); end
    checks++; if (ifc.cfg_out !== 10'h009) begin errors++; $display("FAIL short_cfg_out: got %h want %h", ifc.cfg_out, 10'h009); end
    checks++; if (ifc.cfg_valid !== 1'b0) begin errors++; $display("FAIL short_cfg_valid: got %b want 0", ifc.cfg_valid); end
    checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL short_busy: got %b want 0", ifc.busy); end
    d = CW'($urandom_range(0, (1 << CW) - 1));
    shift_frame(frame_of(d, 0));
    cycle(0, 0, 1, 0, 0);
    checks++; if (ifc.cfg_out !== d) begin errors++; $display("FAIL short_then_valid_cfg: got %h want %h", ifc.cfg_out, d); end
    checks++; if (ifc.cfg_valid !== 1'b1) begin errors++; $display("FAIL short_then_valid_pulse: got %b want 1", ifc.cfg_valid); end
    checks++; if (ifc.load_err !== 1'b1) begin errors++; $display("FAIL short_err_sticky: got %b want 1", ifc.load_err); end
    cycle(0, 0, 0, 0, 0);
  endtask

  task automatic test_chain;
    logic [FW-1:0] f1, f2;
    f1 = frame_of(10'h155, 0);
    f2 = frame_of(10'h2AA, 0);
    cycle(1, 0, 0, 0, 0);
    for (int i = FW - 1; i >= 0; i--) begin
      cycle(0, 0, 0, 1, f1[i]);
      checks++; if (ifc.serial_data_out !== m_sr[FW-1]) begin errors++; $display("FAIL chain_sdo_a[%0d]: got %b want %b", i, ifc.serial_data_out, m_sr[FW-1]); end
    end
    // The first frame emerges MSB-first while the second is shifted in.
    for (int k = 1; k <= FW; k++) begin
      cycle(0, 0, 0, 1, f2[FW-k]);
      if (k < FW) begin
        checks++; if (ifc.serial_data_out !== f1[FW-1-k]) begin errors++; $display("FAIL chain_sdo_b[%0d]: got %b want %b", k, ifc.serial_data_out, f1[FW-1-k]); end
      end
    end
    cycle(0, 0, 1, 0, 0);
    checks++; if (ifc.cfg_out !== 10'h2AA) begin errors++; $display("FAIL chain_cfg_out: got %h want %h", ifc.cfg_out, 10'h2AA); end
    checks++; if (ifc.cfg_valid !== 1'b1) begin errors++; $display("FAIL chain_cfg_valid: got %b want 1", ifc.cfg_valid); end
    cycle(0, 0, 0, 0, 0);
  endtask

  task automatic test_priority;
    logic [CW-1:0] d, nd;
    logic [FW-1:0] f;
    ifc.gpio_defaults = 10'h009;
    cycle(1, 0, 0, 0, 0);
    d = CW'($urandom_range(0, (1 << CW) - 1));
    f = frame_of(d, 0);
    shift_frame(f);
    cycle(0, 0, 1, 1, ~f[FW-2]);
    checks++; if (ifc.cfg_out !== d) begin errors++; $display("FAIL prio_load_cfg: got %h want %h", ifc.cfg_out, d); end
    checks++; if (ifc.serial_data_out !== f[FW-1]) begin errors++; $display("FAIL prio_shift_dropped: got %b want %b", ifc.serial_data_out, f[FW-1]); end
    // Shift during the commit cycle is ignored.
    cycle(0, 0, 0, 1, ~f[FW-2]);
    checks++; if (ifc.serial_data_out !== f[FW-1]) begin errors++; $display("FAIL prio_commit_shift: got %b want %b", ifc.serial_data_out, f[FW-1]); end
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, 1'($urandom_range(0, 1)));
    cycle(0, 1, 0, 0, 0);
    checks++; if (ifc.cfg_out !== 10'h009) begin errors++; $display("FAIL reload_cfg: got %h want %h", ifc.cfg_out, 10'h009); end
    checks++; if (ifc.cfg_valid !== 1'b1) begin errors++; $display("FAIL reload_valid: got %b want 1", ifc.cfg_valid); end
    checks++; if (ifc.busy !== 1'b1) begin errors++; $display("FAIL reload_busy: got %b want 1", ifc.busy); end
    cycle(0, 0, 0, 0, 0);
    // Reload cleared the count, so an immediate load is short.
    cycle(0, 0, 1, 0, 0);
    checks++; if (ifc.load_err !== 1'b1) begin errors++; $display("FAIL reload_cnt_cleared: got %b want 1", ifc.load_err); end
    checks++; if (ifc.cfg_out !== 10'h009) begin errors++; $display("FAIL reload_cfg_kept: got %h want %h", ifc.cfg_out, 10'h009); end
    // Defaults only matter on reset/reload; reload outranks a same-cycle load.
    nd = 10'h3C3;
    ifc.gpio_defaults = nd;
    shift_frame(frame_of(10'h111, 0));
    checks++; if (ifc.cfg_out !== 10'h009) begin errors++; $display("FAIL dflt_ignored: got %h want %h", ifc.cfg_out, 10'h009); end
    cycle(0, 1, 1, 0, 0);
    checks++; if (ifc.cfg_out !== nd) begin errors++; $display("FAIL reload_over_load: got %h want %h", ifc.cfg_out, nd); end
    checks++; if (ifc.load_err !== 1'b1) begin errors++; $display("FAIL reload_keeps_err: got %b want 1", ifc.load_err); end
    cycle(0, 0, 0, 0, 0);
    ifc.gpio_defaults = 10'h009;
  endtask

`ifdef GPIO_CFG_PARITY_EN
  task automatic test_parity;
    cycle(1, 0, 0, 0, 0);
    shift_frame({10'h3A5, 1'b0});
    cycle(0, 0, 1, 0, 0);
    checks++; if (ifc.cfg_out !== 10'h3A5) begin errors++; $display("FAIL par_good_cfg: got %h want %h", ifc.cfg_out, 10'h3A5); end
    checks++; if (ifc.load_err !== 1'b0) begin errors++; $display("FAIL par_good_err: got %b want 0", ifc.load_err); end
    cycle(0, 0, 0, 0, 0);
    shift_frame({10'h0F0, 1'b1});
    cycle(0, 0, 1, 0, 0);
    checks++; if (ifc.load_err !== 1'b1) begin errors++; $display("FAIL par_bad_err: got %b want 1", ifc.load_err); end
    checks++; if (ifc.cfg_out !== 10'h3A5) begin errors++; $display("FAIL par_bad_cfg: got %h want %h", ifc.cfg_out, 10'h3A5); end
    checks++; if (ifc.cfg_valid !== 1'b0) begin errors++; $display("FAIL par_bad_valid: got %b want 0", ifc.cfg_valid); end
  endtask
`endif

  task automatic test_random;
    bit r, rl, ld, sh;
    cycle(1, 0, 0, 0, 0);
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 49) == 0) ifc.gpio_defaults = CW'($urandom_range(0, (1 << CW) - 1));
      r  = ($urandom_range(0, 149) == 0);
      rl = ($urandom_range(0, 39) == 0);
      ld = ($urandom_range(0, 9) == 0);
      sh = ($urandom_range(0, 3) != 0);
      cycle(r, rl, ld, sh, 1'($urandom_range(0, 1)));
      checks++; if (ifc.cfg_out !== m_cfg) begin errors++; $display("FAIL rnd_cfg_out[%0d]: got %h want %h", n, ifc.cfg_out, m_cfg); end
      checks++; if (ifc.serial_data_out !== m_sr[FW-1]) begin errors++; $display("FAIL rnd_sdo[%0d]: got %b want %b", n, ifc.serial_data_out, m_sr[FW-1]); end
      checks++; if (ifc.cfg_valid !== m_commit) begin errors++; $display("FAIL rnd_valid[%0d]: got %b want %b", n, ifc.cfg_valid, m_commit); end
      checks++; if (ifc.busy !== m_commit) begin errors++; $display("FAIL rnd_busy[%0d]: got %b want %b", n, ifc.busy, m_commit); end
      checks++; if (ifc.load_err !== m_err) begin errors++; $display("FAIL rnd_load_err[%0d]: got %b want %b", n, ifc.load_err, m_err); end
    end
  endtask

  initial begin
    ifc.gpio_defaults   = 10'h009;
    ifc.defaults_reload = 1'b0;
    ifc.serial_shift    = 1'b0;
    ifc.serial_data_in  = 1'b0;
    ifc.serial_load     = 1'b0;
    m_sr = '0; m_cnt = 0; m_cfg = '0; m_err = 0; m_commit = 0;
    test_reset();
    test_load_frame();
    test_short_frame();
    test_chain();
    test_priority();
`ifdef GPIO_CFG_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
